// File: rtl/l2_cache_pending_miss_tracker.sv
// Pending-miss tracker for the L2 tag stage.
// Each entry holds one outstanding line fill. Later requests to a pending line
// are flagged as duplicates and counted against that entry. A restarted fill
// releases its entry and reports how many requests merged onto it.
module l2_cache_pending_miss_tracker #(
  parameter int QUEUE_SIZE            = 16,
  parameter int KEY_WIDTH             = 26,
  parameter int MAX_WAITERS           = 7,
  parameter int ALMOST_FULL_THRESHOLD = QUEUE_SIZE - 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               request_valid,
  input  logic [KEY_WIDTH-1:0]               request_addr,
  input  logic                               enqueue_fill_request,
  input  logic                               l2r_l2_fill,
  output logic                               duplicate_request,
  output logic [$clog2(MAX_WAITERS+1)-1:0]   fill_waiter_count,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]    pending_count,
  output logic                               almost_full,
  output logic                               full,
  output logic                               error_overflow,
  output logic                               error_orphan_fill
);

  localparam int WAITER_WIDTH = $clog2(MAX_WAITERS + 1);
  localparam int CNT_WIDTH    = $clog2(QUEUE_SIZE + 1);
  localparam int IDX_WIDTH    = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;

  localparam logic [WAITER_WIDTH-1:0] W_SAT   = WAITER_WIDTH'(MAX_WAITERS);
  localparam logic [CNT_WIDTH-1:0]    C_FULL  = CNT_WIDTH'(QUEUE_SIZE);
  localparam logic [CNT_WIDTH-1:0]    C_AFULL = CNT_WIDTH'(ALMOST_FULL_THRESHOLD);

  logic                    r_valid   [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0]    r_key     [QUEUE_SIZE];
  logic [WAITER_WIDTH-1:0] r_waiters [QUEUE_SIZE];
  logic [CNT_WIDTH-1:0]    r_pending_count;
  logic                    r_err_overflow;
  logic                    r_err_orphan;

  logic [QUEUE_SIZE-1:0]   w_valid;
  logic [QUEUE_SIZE-1:0]   w_match;
  logic                    w_hit;
  logic [IDX_WIDTH-1:0]    w_hit_idx;
  logic [IDX_WIDTH-1:0]    w_free_idx;
  logic                    w_release;
  logic                    w_merge;
  logic                    w_alloc;
  logic                    w_overflow;
  logic                    w_orphan;

  // Per-entry compare against the incoming line index.
  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_cmp
      assign w_valid[gi] = r_valid[gi];
      assign w_match[gi] = r_valid[gi] && (r_key[gi] == request_addr);
    end
  endgenerate

  assign w_hit = |w_match;

  // Lowest-index encoders for the matching entry and the first free entry.
  always_comb begin
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = IDX_WIDTH'(i);
      if (!w_valid[i]) w_free_idx = IDX_WIDTH'(i);
    end
  end

  // A fill never allocates: on a miss it is an orphan, on a hit it releases.
  assign w_release  = request_valid && w_hit && l2r_l2_fill;
  assign w_merge    = request_valid && w_hit && !l2r_l2_fill;
  assign w_alloc    = request_valid && !w_hit && !l2r_l2_fill && enqueue_fill_request && !full;
  assign w_overflow = request_valid && !w_hit && !l2r_l2_fill && enqueue_fill_request && full;
  assign w_orphan   = request_valid && !w_hit && l2r_l2_fill;

  assign duplicate_request = w_merge;
  assign fill_waiter_count = w_release ? r_waiters[w_hit_idx] : '0;
  assign pending_count     = r_pending_count;
  assign full              = (r_pending_count == C_FULL);
  assign almost_full       = (r_pending_count >= C_AFULL);
  assign error_overflow    = r_err_overflow;
  assign error_orphan_fill = r_err_orphan;

  generate
    for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_entry
      // Entry state: flush wins, then release / merge / allocate for this slot.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid[gi]   <= 1'b0;
          r_key[gi]     <= '0;
          r_waiters[gi] <= '0;
        end else if (flush) begin
          r_valid[gi]   <= 1'b0;
          r_waiters[gi] <= '0;
        end else if (w_release && (w_hit_idx == IDX_WIDTH'(gi))) begin
          r_valid[gi]   <= 1'b0;
          r_waiters[gi] <= '0;
        end else if (w_merge && (w_hit_idx == IDX_WIDTH'(gi))) begin
          if (r_waiters[gi] != W_SAT) r_waiters[gi] <= r_waiters[gi] + 1'b1;
        end else if (w_alloc && (w_free_idx == IDX_WIDTH'(gi))) begin
          r_valid[gi]   <= 1'b1;
          r_key[gi]     <= request_addr;
          r_waiters[gi] <= '0;
        end
      end
    end
  endgenerate

  // Occupancy moves by at most one per cycle since only one request is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_pending_count <= '0;
    else if (flush)     r_pending_count <= '0;
    else if (w_alloc)   r_pending_count <= r_pending_count + 1'b1;
    else if (w_release) r_pending_count <= r_pending_count - 1'b1;
  end

  // Sticky error flags; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_overflow <= 1'b0;
      r_err_orphan   <= 1'b0;
    end else if (!flush) begin
      if (w_overflow) r_err_overflow <= 1'b1;
      if (w_orphan)   r_err_orphan   <= 1'b1;
    end
  end

  // A line may be pending in at most one entry.
  a_single_match: assert property (@(posedge clk) disable iff (reset) $onehot0(w_match));

  // The occupancy counter must track the set valid bits exactly.
  a_count_matches: assert property (@(posedge clk) disable iff (reset)
    r_pending_count == CNT_WIDTH'($countones(w_valid)));

endmodule

// File: tb/tb_l2_cache_pending_miss_tracker.sv
// Bench for the pending-miss tracker: directed scenarios followed by random
// traffic, all compared against a line-keyed reference model.
module tb_l2_cache_pending_miss_tracker;

  localparam int QS  = 4;
  localparam int KW  = 8;
  localparam int MW  = 3;
  localparam int AFT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          request_valid;
  logic [KW-1:0] request_addr;
  logic          enqueue_fill_request;
  logic          l2r_l2_fill;
  logic          duplicate_request;
  logic [1:0]    fill_waiter_count;
  logic [2:0]    pending_count;
  logic          almost_full;
  logic          full;
  logic          error_overflow;
  logic          error_orphan_fill;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: pending line -> merged-request count.
  int m_cnt[int];
  bit m_ovf;
  bit m_orph;

  l2_cache_pending_miss_tracker #(
    .QUEUE_SIZE(QS),
    .KEY_WIDTH(KW),
    .MAX_WAITERS(MW),
    .ALMOST_FULL_THRESHOLD(AFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .request_valid(request_valid),
    .request_addr(request_addr),
    .enqueue_fill_request(enqueue_fill_request),
    .l2r_l2_fill(l2r_l2_fill),
    .duplicate_request(duplicate_request),
    .fill_waiter_count(fill_waiter_count),
    .pending_count(pending_count),
    .almost_full(almost_full),
    .full(full),
    .error_overflow(error_overflow),
    .error_orphan_fill(error_orphan_fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = m_cnt.num();
    chk("pending_count", 32'(pending_count), n);
    chk("full", 32'(full), (n == QS) ? 1 : 0);
    chk("almost_full", 32'(almost_full), (n >= AFT) ? 1 : 0);
    chk("error_overflow", 32'(error_overflow), 32'(m_ovf));
    chk("error_orphan_fill", 32'(error_orphan_fill), 32'(m_orph));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dup"}, 32'(duplicate_request), 0);
    chk({tag, "_fwc"}, 32'(fill_waiter_count), 0);
    chk({tag, "_pending"}, 32'(pending_count), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(error_overflow), 0);
    chk({tag, "_orph"}, 32'(error_orphan_fill), 0);
  endtask

  // One request cycle: drive, check combinational lookup, clock, update model.
  task automatic cycle(input bit v, input int a, input bit enq, input bit fill, input bit fl);
    bit hit;
    int exp_fwc;
    request_valid        = v;
    request_addr         = KW'(a);
    enqueue_fill_request = enq;
    l2r_l2_fill          = fill;
    flush                = fl;
    #2;
    hit     = m_cnt.exists(a);
    exp_fwc = 0;
    if (v && hit && fill) exp_fwc = m_cnt[a];
    chk("duplicate_request", 32'(duplicate_request), (v && hit && !fill) ? 1 : 0);
    chk("fill_waiter_count", 32'(fill_waiter_count), exp_fwc);
    check_state();
    $display("txn %0d v=%0b a=%02h enq=%0b fill=%0b flush=%0b dup=%0b fwc=%0d cnt=%0d",
             txn, v, a, enq, fill, fl, duplicate_request, fill_waiter_count, pending_count);
    txn++;
    @(posedge clk);
    if (fl) begin
      m_cnt.delete();
    end else if (v) begin
      if (hit && fill) m_cnt.delete(a);
      else if (hit) begin
        if (m_cnt[a] < MW) m_cnt[a] = m_cnt[a] + 1;
      end
      else if (fill) m_orph = 1'b1;
      else if (enq) begin
        if (m_cnt.num() == QS) m_ovf = 1'b1;
        else m_cnt[a] = 0;
      end
    end
    #1;
  endtask

  // Reset asserted between clock edges; outputs must clear with no edge.
  task automatic async_reset(input int a);
    request_valid        = 1'b1;
    request_addr         = KW'(a);
    enqueue_fill_request = 1'b0;
    l2r_l2_fill          = 1'b0;
    flush                = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    $display("txn %0d async reset at %0t", txn, $time);
    txn++;
    m_cnt.delete();
    m_ovf  = 1'b0;
    m_orph = 1'b0;
    @(negedge clk);
    reset         = 1'b0;
    request_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    reset                = 1'b1;
    flush                = 1'b0;
    request_valid        = 1'b0;
    request_addr         = '0;
    enqueue_fill_request = 1'b0;
    l2r_l2_fill          = 1'b0;
    m_ovf                = 1'b0;
    m_orph               = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Allocate, duplicate, release with one waiter.
    cycle(1, 'h10, 1, 0, 0);
    cycle(1, 'h10, 0, 0, 0);
    cycle(1, 'h10, 0, 1, 0);
    cycle(0, 'h00, 0, 0, 0);

    // Waiter counter saturation.
    cycle(1, 'h20, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 'h20, 0, 0, 0);
    cycle(1, 'h20, 0, 1, 0);
    cycle(0, 'h00, 0, 0, 0);

    // Fill up, overflow, free a middle entry, reuse it.
    for (int i = 1; i <= 5; i++) cycle(1, i, 1, 0, 0);
    cycle(1, 'h2, 0, 1, 0);
    cycle(1, 'h6, 1, 0, 0);
    cycle(0, 'h00, 0, 0, 0);

    // Orphan fill.
    cycle(1, 'h99, 0, 1, 0);
    cycle(0, 'h00, 0, 0, 0);

    // Flush with a concurrent miss-enqueue.
    cycle(1, 'h4, 0, 1, 0);
    cycle(1, 'h7, 1, 0, 1);
    cycle(1, 'h1, 0, 0, 0);
    cycle(1, 'h7, 0, 0, 0);

    // Release then immediate re-allocation of the same line.
    cycle(1, 'h30, 1, 0, 0);
    cycle(1, 'h30, 0, 1, 0);
    cycle(1, 'h30, 1, 0, 0);
    cycle(1, 'h30, 0, 0, 0);

    // Mid-stream asynchronous reset with errors set.
    cycle(1, 'h1, 1, 0, 0);
    cycle(1, 'h2, 1, 0, 0);
    cycle(0, 'h00, 0, 0, 0);
    async_reset('h1);
    cycle(0, 'h00, 0, 0, 0);

    // Random traffic over a small line pool to force hits and fills.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset($urandom_range(0, 7));
      end else begin
        r = $urandom_range(0, 2);
        cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 7),
              (r == 0), (r == 1), ($urandom_range(0, 39) == 0));
      end
    end
    cycle(0, 'h00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
